uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DBIT, 8, data bits per received word.
REQ-002 Parameter FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.
REQ-003 Parameter DVSR_W, 11, baud divisor width.
REQ-004 Parameter TO_TICKS, 640, oversample ticks of idle before timeout (40 bit-times at x16).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 dvsr  in  DVSR_W  baud divisor; s_tick period = dvsr+1 clocks.
REQ-008 s_tick  out  1  one-cycle oversample tick to the receiver.
REQ-009 rx_done_tick  in  1  receiver word-complete strobe.
REQ-010 rx_data  in  DBIT  receiver data, valid when rx_done_tick=1.
REQ-011 rd_uart  in  1  pop request from host.
REQ-012 r_data  out  DBIT  FIFO head word, show-ahead.
REQ-013 rx_empty  out  1  FIFO empty.
REQ-014 rx_full  out  1  FIFO full.
REQ-015 rx_level  out  FIFO_AW+1  words held, 0..depth.
REQ-016 overrun  out  1  sticky, a word was dropped.
REQ-017 clr_overrun  in  1  clears overrun.
REQ-018 timeout_irq  out  1  FIFO non-empty and line idle.

Function
REQ-019 Tick counter SHALL count 0..dvsr, drive s_tick=1 for exactly the cycle where count>=dvsr, then wrap to 0; dvsr=0 gives s_tick every cycle.
REQ-020 A dvsr change SHALL take effect without glitching; if count already exceeds the new dvsr, the counter SHALL wrap on the next cycle.
REQ-021 rx_done_tick with FIFO not full SHALL write rx_data at the tail; rx_level increments the following cycle.
REQ-022 rd_uart with FIFO not empty SHALL advance the head; rd_uart on empty SHALL be ignored with no state change.
REQ-023 r_data SHALL present the head word combinationally from storage; its value when rx_empty=1 is don't-care.
REQ-024 Simultaneous push and pop with FIFO neither empty nor full: both SHALL occur; rx_level unchanged.
REQ-025 Simultaneous push and pop when full: both SHALL occur, no overrun; when empty: push only.
REQ-026 Push when full without pop: word SHALL be dropped and overrun set the next cycle.
REQ-027 overrun SHALL stay 1 until clr_overrun; a set and a clear in the same cycle SHALL leave overrun=1.
REQ-028 Pointers SHALL wrap modulo depth; rx_full = (rx_level==depth), rx_empty = (rx_level==0).

Reset
REQ-029 On reset: tick count 0, s_tick 0, pointers 0, rx_level 0, rx_empty 1, rx_full 0, overrun 0, timeout_irq 0, timeout FSM TO_IDLE.
REQ-030 Reset mid-operation SHALL discard all FIFO contents; storage array need not be cleared.

Configuration
REQ-031 Macro UART_RX_TIMEOUT_EN defined: timeout FSM TO_IDLE/TO_COUNT/TO_FIRED is compiled in.
REQ-032 TO_IDLE->TO_COUNT when FIFO non-empty; TO_COUNT increments on s_tick, clears on any push or pop, ->TO_FIRED on the s_tick at which count reaches TO_TICKS-1.
REQ-033 TO_FIRED drives timeout_irq=1; exits to TO_COUNT (count 0) on push or pop; any state ->TO_IDLE when FIFO becomes empty.
REQ-034 Macro undefined: no timeout counter or FSM; timeout_irq tied 0.

Structure
REQ-035 Shared package uart_pkg SHALL hold DBIT/DVSR_W defaults and timeout state encodings.
REQ-036 FIFO storage and pointers SHALL be a sub-module rx_fifo; tick generator and timeout FSM stay in uart_rx_ctrl.

Verification
REQ-037 dvsr=3 -> s_tick every 4th clock; dvsr=0 -> s_tick every clock; dvsr changed 10->2 at count 7 -> wrap next cycle.
REQ-038 Push 0xA5,0x3C then pop twice -> r_data 0xA5 then 0x3C, rx_level 2->1->0, rx_empty=1.
REQ-039 Push 17 words into depth 16 -> 17th dropped, overrun=1, rx_level=16; clr_overrun -> 0; simultaneous set+clr -> 1.
REQ-040 Full FIFO, push 0x55 with pop same cycle -> no overrun, rx_level stays 16, 0x55 is last word read.
REQ-041 UART_RX_TIMEOUT_EN, one word held, no activity -> timeout_irq=1 after 640 s_ticks; pop -> 0; macro undefined -> never asserts.
REQ-042 Reset asserted with 5 words held -> rx_level 0, rx_empty 1, overrun 0 immediately, asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared defaults and timeout-FSM state encodings for the UART receive controller.
package uart_pkg;

  localparam int DBIT_DEF     = 8;
  localparam int FIFO_AW_DEF  = 4;
  localparam int DVSR_W_DEF   = 11;
  localparam int TO_TICKS_DEF = 640;

  typedef enum logic [1:0] {
    TO_IDLE  = 2'd0,
    TO_COUNT = 2'd1,
    TO_FIRED = 2'd2
  } to_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Receive FIFO: show-ahead head word, level count and sticky overrun flag.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT = DBIT_DEF,
  parameter int AW   = FIFO_AW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            rd,
  input  logic            clr_overrun,
  output logic [DBIT-1:0] r_data,
  output logic            empty,
  output logic            full,
  output logic [AW:0]     level,
  output logic            overrun
);

  localparam int DEPTH = 2 ** AW;

  logic [DBIT-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            drop;

  assign empty  = (level == '0);
  assign full   = (level == (AW+1)'(DEPTH));
  assign pop    = rd & ~empty;
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign push   = wr & (~full | pop);
  assign drop   = wr & ~push;
  assign r_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      // Set wins over clear so a drop is never lost.
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generator, receive FIFO and idle-timeout IRQ.
// Timeout FSM compiled in only when UART_RX_TIMEOUT_EN is defined.
//   state    | meaning
//   TO_IDLE  | FIFO empty, timer parked
//   TO_COUNT | FIFO holds data, counting idle s_ticks
//   TO_FIRED | idle limit reached, timeout_irq asserted
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT     = DBIT_DEF,
  parameter int FIFO_AW  = FIFO_AW_DEF,
  parameter int DVSR_W   = DVSR_W_DEF,
  parameter int TO_TICKS = TO_TICKS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              s_tick,
  input  logic              rx_done_tick,
  input  logic [DBIT-1:0]   rx_data,
  input  logic              rd_uart,
  output logic [DBIT-1:0]   r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic [FIFO_AW:0]  rx_level,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic              timeout_irq
);

  logic [DVSR_W-1:0] tick_cnt;

  // >= rather than == so a shrinking divisor wraps immediately instead of running to 2**DVSR_W.
  assign s_tick = ~reset & (tick_cnt >= dvsr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                tick_cnt <= '0;
    else if (tick_cnt >= dvsr) tick_cnt <= '0;
    else                      tick_cnt <= tick_cnt + DVSR_W'(1);
  end

  rx_fifo #(.DBIT(DBIT), .AW(FIFO_AW)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr          (rx_done_tick),
    .w_data      (rx_data),
    .rd          (rd_uart),
    .clr_overrun (clr_overrun),
    .r_data      (r_data),
    .empty       (rx_empty),
    .full        (rx_full),
    .level       (rx_level),
    .overrun     (overrun)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_TICKS);

  to_state_t       to_state, to_state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            activity;

  assign activity = rx_done_tick | (rd_uart & ~rx_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_state <= TO_IDLE;
      to_cnt   <= '0;
    end else begin
      to_state <= to_state_nxt;
      to_cnt   <= to_cnt_nxt;
    end
  end

  always_comb begin
    to_state_nxt = to_state;
    to_cnt_nxt   = to_cnt;
    if (rx_empty) begin
      to_state_nxt = TO_IDLE;
      to_cnt_nxt   = '0;
    end else begin
      case (to_state)
        TO_IDLE: begin
          to_state_nxt = TO_COUNT;
          to_cnt_nxt   = '0;
        end
        TO_COUNT: begin
          if (activity) to_cnt_nxt = '0;
          else if (s_tick) begin
            if (to_cnt == TO_W'(TO_TICKS - 1)) to_state_nxt = TO_FIRED;
            else                               to_cnt_nxt   = to_cnt + TO_W'(1);
          end
        end
        TO_FIRED: begin
          if (activity) begin
            to_state_nxt = TO_COUNT;
            to_cnt_nxt   = '0;
          end
        end
        default: to_state_nxt = TO_IDLE;
      endcase
    end
  end

  assign timeout_irq = (to_state == TO_FIRED);
`else
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl; expected words queued at push, checked by a pop monitor.
module tb_uart_rx_ctrl;

  localparam int DBIT    = 8;
  localparam int FIFO_AW = 4;
  localparam int DVSR_W  = 11;
  localparam int DEPTH   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DVSR_W-1:0] dvsr = 11'd3;
  logic              s_tick;
  logic              rx_done_tick = 1'b0;
  logic [DBIT-1:0]   rx_data = '0;
  logic              rd_uart = 1'b0;
  logic [DBIT-1:0]   r_data;
  logic              rx_empty;
  logic              rx_full;
  logic [FIFO_AW:0]  rx_level;
  logic              overrun;
  logic              clr_overrun = 1'b0;
  logic              timeout_irq;

  int checks   = 0;
  int failures = 0;
  int m_lvl    = 0;
  logic [DBIT-1:0] sb [$];

  uart_rx_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .dvsr         (dvsr),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rd_uart      (rd_uart),
    .r_data       (r_data),
    .rx_empty     (rx_empty),
    .rx_full      (rx_full),
    .rx_level     (rx_level),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun),
    .timeout_irq  (timeout_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must present the oldest queued word.
  always @(negedge clk) begin
    if (!reset && rd_uart && !rx_empty) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h required=none", r_data);
      end else begin
        check("r_data_pop", r_data, sb.pop_front());
      end
    end
  end

  // One clock of stimulus, entered and left at posedge+1.
  task automatic step(input logic push, input logic [DBIT-1:0] d, input logic pop, input logic clr);
    logic do_pop;
    do_pop = pop && (m_lvl > 0);
    if (push && (m_lvl < DEPTH || do_pop)) begin
      sb.push_back(d);
      m_lvl++;
    end
    if (do_pop) m_lvl--;
    rx_done_tick = push;
    rx_data      = d;
    rd_uart      = pop;
    clr_overrun  = clr;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    rd_uart      = 1'b0;
    clr_overrun  = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (s_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;

    repeat (2) @(posedge clk);
    #1;
    check("rst_level", rx_level, 0);
    check("rst_empty", rx_empty, 1);
    check("rst_full", rx_full, 0);
    check("rst_overrun", overrun, 0);
    check("rst_irq", timeout_irq, 0);
    check("rst_s_tick", s_tick, 0);
    reset = 1'b0;

    // Tick generator with dvsr=3: one tick per 4 clocks.
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_tick) n++;
    end
    check("tick_dvsr3_count", n, 10);
    wait_tick(ok);
    check("tick_dvsr3_found", ok, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tick && n < 20);
    check("tick_dvsr3_gap", n, 4);

    @(posedge clk); #1;
    dvsr = 11'd0;
    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (s_tick) n++;
    end
    check("tick_dvsr0_count", n, 16);

    // Divisor 10 -> 2 while the count sits at 7.
    @(posedge clk); #1;
    dvsr = 11'd10;
    wait_tick(ok);
    check("tick_dvsr10_found", ok, 1);
    repeat (8) @(posedge clk);
    #1;
    dvsr = 11'd2;
    @(negedge clk); check("tick_shrink_now", s_tick, 1);
    @(negedge clk); check("tick_shrink_c0", s_tick, 0);
    @(negedge clk); check("tick_shrink_c1", s_tick, 0);
    @(negedge clk); check("tick_shrink_c2", s_tick, 1);
    @(posedge clk); #1;
    dvsr = 11'd0;

    // Two words in, two out.
    step(1, 8'hA5, 0, 0);
    check("lvl_after_a5", rx_level, 1);
    step(1, 8'h3C, 0, 0);
    check("lvl_after_3c", rx_level, 2);
    check("head_a5", r_data, 8'hA5);
    step(0, 8'h00, 1, 0);
    check("lvl_pop1", rx_level, 1);
    check("head_3c", r_data, 8'h3C);
    step(0, 8'h00, 1, 0);
    check("lvl_pop2", rx_level, 0);
    check("empty_pop2", rx_empty, 1);
    step(0, 8'h00, 1, 0);
    check("lvl_pop_empty", rx_level, 0);
    check("empty_pop_empty", rx_empty, 1);

    // Push and pop together with two words held.
    step(1, 8'hB1, 0, 0);
    step(1, 8'hB2, 0, 0);
    step(1, 8'hB3, 1, 0);
    check("lvl_pushpop_mid", rx_level, 2);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    check("lvl_mid_drained", rx_level, 0);

    // Push and pop together on an empty FIFO: only the push happens.
    step(1, 8'hC7, 1, 0);
    check("lvl_pushpop_empty", rx_level, 1);
    check("head_c7", r_data, 8'hC7);
    step(0, 8'h00, 1, 0);

    // Idle timeout with one word held, s_tick every clock.
    step(1, 8'h11, 0, 0);
    n = 0;
`ifdef UART_RX_TIMEOUT_EN
    while (!timeout_irq && n < 700) begin
      @(posedge clk); #1;
      n++;
    end
    check("to_irq_fired", timeout_irq, 1);
    // One edge to leave TO_IDLE, then 640 ticks.
    check("to_irq_latency", n, 641);
    step(0, 8'h00, 1, 0);
    check("to_irq_cleared", timeout_irq, 0);
`else
    repeat (700) begin
      @(posedge clk); #1;
      if (timeout_irq) n++;
    end
    check("to_irq_never", n, 0);
    step(0, 8'h00, 1, 0);
    check("to_irq_after_pop", timeout_irq, 0);
`endif
    check("lvl_after_timeout", rx_level, 0);

    // Overflow: 17th word dropped.
    for (int i = 0; i < 17; i++) step(1, 8'h20 + 8'(i), 0, 0);
    check("ovf_level", rx_level, 16);
    check("ovf_full", rx_full, 1);
    check("ovf_overrun", overrun, 1);
    step(0, 8'h00, 0, 1);
    check("ovf_cleared", overrun, 0);
    step(1, 8'h77, 0, 1);
    check("ovf_set_and_clr", overrun, 1);
    check("ovf_level_hold", rx_level, 16);
    step(0, 8'h00, 0, 1);

    // Full with push and pop together: no overrun, 0x55 ends up last.
    step(1, 8'h55, 1, 0);
    check("full_pushpop_ovr", overrun, 0);
    check("full_pushpop_lvl", rx_level, 16);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0);
    check("last_word_55", r_data, 8'h55);
    step(0, 8'h00, 1, 0);
    check("drain_level", rx_level, 0);
    check("drain_sb_empty", sb.size(), 0);

    // Asynchronous reset with 5 words held and overrun set.
    for (int i = 0; i < 17; i++) step(1, 8'h40 + 8'(i), 0, 0);
    for (int i = 0; i < 11; i++) step(0, 8'h00, 1, 0);
    check("pre_rst_level", rx_level, 5);
    check("pre_rst_overrun", overrun, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_level", rx_level, 0);
    check("arst_empty", rx_empty, 1);
    check("arst_overrun", overrun, 0);
    check("arst_full", rx_full, 0);
    sb.delete();
    m_lvl = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, 8'h9E, 0, 0);
    check("post_rst_level", rx_level, 1);
    step(0, 8'h00, 1, 0);
    check("post_rst_empty", rx_empty, 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
